// File: rtl/knn_pkg.sv
`default_nettype none
// ==========================================================================
// knn_pkg -- FSM encoding, limits and neighbour weighting for knn_voter
// Rev 1.0
// ==========================================================================
package knn_pkg;

  localparam int KNN_K_MAX = 10;
  localparam int KNN_CW    = 7;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_SCAN  = 3'd4,
    S_OUT   = 3'd5
  } knn_state_e;

  // Rank 0 (nearest) carries the full weight k, the farthest carries 1.
  function automatic logic [KNN_CW-1:0] knn_weight(input logic [3:0] rank, input int k);
    return KNN_CW'(k) - KNN_CW'(rank);
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_vote_cnt.sv
`default_nettype none
// ==========================================================================
// knn_vote_cnt -- per-class saturating vote counters, one increment port
// Rev 1.0
// ==========================================================================
module knn_vote_cnt #(
  parameter int NCLASS = 4,
  parameter int LW     = $clog2(NCLASS),
  parameter int CW     = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc_en,
  input  logic [LW-1:0] inc_cls,
  input  logic [CW-1:0] inc_w,
  input  logic [LW-1:0] rd_cls,
  output logic [CW-1:0] rd_cnt
);

  logic [CW-1:0] cnt_q [NCLASS];
  logic [CW-1:0] cnt_d [NCLASS];

  // A label with no matching counter (>= NCLASS) simply hits nothing.
  for (genvar i = 0; i < NCLASS; i++) begin : g_cnt
    logic [CW:0] sum;

    always_comb begin
      sum      = {1'b0, cnt_q[i]} + {1'b0, inc_w};
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (inc_en && (inc_cls == LW'(i))) begin
        cnt_d[i] = sum[CW] ? '1 : sum[CW-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCLASS; i++) begin
      if (rd_cls == LW'(i)) begin
        rd_cnt = cnt_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/knn_voter.sv
`default_nettype none
// ==========================================================================
// knn_voter -- walks the sorter's K-NN list, votes on labels, reports argmax
// Rev 1.0   Optional: KNN_VOTER_WEIGHTED_EN (rank r votes with weight K-r)
// ==========================================================================
module knn_voter
  import knn_pkg::*;
#(
  parameter int K      = 10,
  parameter int NCLASS = 4,
  parameter int IW     = 8,
  parameter int LW     = $clog2(NCLASS),
  parameter int CW     = KNN_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [IW-1:0] npts,
  output logic [3:0]    sel,
  input  logic [IW-1:0] idx_in,
  output logic [IW-1:0] lbl_addr,
  output logic          lbl_re,
  input  logic [LW-1:0] lbl_data,
  output logic          busy,
  output logic          class_valid,
  output logic [LW-1:0] class_out,
  output logic [CW-1:0] votes_out
);

  knn_state_e    state_q, state_d;
  logic [3:0]    n_q, n_d;
  logic [3:0]    rank_q, rank_d;
  logic          rd_vld_q;
  logic [LW-1:0] scan_q, scan_d;
  logic [LW-1:0] best_cls_q, best_cls_d;
  logic [CW-1:0] best_val_q, best_val_d;
  logic          class_valid_q, class_valid_d;
  logic [LW-1:0] class_out_q, class_out_d;
  logic [CW-1:0] votes_out_q, votes_out_d;

  logic [3:0]    w_n;
  logic [CW-1:0] w_weight;
  logic [CW-1:0] w_scan_cnt;
  logic          w_better;

  // Unfilled sorter slots beyond npts are never read.
  assign w_n = (npts < IW'(K)) ? 4'(npts) : 4'(K);

`ifdef KNN_VOTER_WEIGHTED_EN
  logic [3:0] rd_rank_q;
  assign w_weight = CW'(knn_weight(rd_rank_q, K));
`else
  assign w_weight = CW'(1);
`endif

  // Strict compare keeps the lowest class on ties; class 0 seeds the best.
  assign w_better = (scan_q == '0) || (w_scan_cnt > best_val_q);

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    rank_d      = rank_q;
    scan_d      = scan_q;
    best_cls_d  = best_cls_q;
    best_val_d  = best_val_q;
    class_out_d = class_out_q;
    votes_out_d = votes_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          n_d     = w_n;
        end
      end
      S_CLR: begin
        rank_d = '0;
        scan_d = '0;
        if (n_q == 4'd0) begin
          state_d     = S_OUT;
          class_out_d = '0;
          votes_out_d = '0;
        end else begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        rank_d = rank_q + 4'd1;
        if (rank_q == n_q - 4'd1) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (w_better) begin
          best_cls_d = scan_q;
          best_val_d = w_scan_cnt;
        end
        scan_d = scan_q + LW'(1);
        if (scan_q == LW'(NCLASS - 1)) begin
          state_d     = S_OUT;
          class_out_d = best_cls_d;
          votes_out_d = best_val_d;
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    class_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      rank_q        <= '0;
      rd_vld_q      <= 1'b0;
      scan_q        <= '0;
      best_cls_q    <= '0;
      best_val_q    <= '0;
      class_valid_q <= 1'b0;
      class_out_q   <= '0;
      votes_out_q   <= '0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      rank_q        <= rank_d;
      rd_vld_q      <= (state_q == S_RD);
      scan_q        <= scan_d;
      best_cls_q    <= best_cls_d;
      best_val_q    <= best_val_d;
      class_valid_q <= class_valid_d;
      class_out_q   <= class_out_d;
      votes_out_q   <= votes_out_d;
    end
  end

`ifdef KNN_VOTER_WEIGHTED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rank_q <= '0;
    end else begin
      rd_rank_q <= rank_q;
    end
  end
`endif

  // The label for a read issued in RD arrives one cycle later with rd_vld_q.
  knn_vote_cnt #(
    .NCLASS (NCLASS),
    .LW     (LW),
    .CW     (CW)
  ) u_vote_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == S_CLR),
    .inc_en  (rd_vld_q),
    .inc_cls (lbl_data),
    .inc_w   (w_weight),
    .rd_cls  (scan_q),
    .rd_cnt  (w_scan_cnt)
  );

  assign sel         = (state_q == S_RD) ? rank_q : 4'd0;
  assign lbl_re      = (state_q == S_RD);
  assign lbl_addr    = (state_q == S_RD) ? idx_in : '0;
  assign busy        = (state_q != S_IDLE);
  assign class_valid = class_valid_q;
  assign class_out   = class_out_q;
  assign votes_out   = votes_out_q;

endmodule
`default_nettype wire

// File: tb/tb_knn_voter.sv
`default_nettype none
// tb_knn_voter -- directed and randomized queries of knn_voter checked
// against a per-class vote tally model computed in the bench.
module tb_knn_voter;

  localparam int K      = 10;
  localparam int NCLASS = 4;
  localparam int IW     = 8;
  localparam int LW     = 2;
  localparam int CW     = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] npts;
  logic [3:0]    sel;
  logic [IW-1:0] idx_in;
  logic [IW-1:0] lbl_addr;
  logic          lbl_re;
  logic [LW-1:0] lbl_data;
  logic          busy;
  logic          class_valid;
  logic [LW-1:0] class_out;
  logic [CW-1:0] votes_out;

  logic [IW-1:0] idx_list [16];
  logic [LW-1:0] lbl_mem  [256];
  int            lab      [K];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  knn_voter #(.K(K), .NCLASS(NCLASS), .IW(IW), .LW(LW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .npts        (npts),
    .sel         (sel),
    .idx_in      (idx_in),
    .lbl_addr    (lbl_addr),
    .lbl_re      (lbl_re),
    .lbl_data    (lbl_data),
    .busy        (busy),
    .class_valid (class_valid),
    .class_out   (class_out),
    .votes_out   (votes_out)
  );

  // Sorter rank-select port and synchronous label memory.
  assign idx_in = idx_list[sel];
  always @(posedge clk) if (lbl_re) lbl_data <= lbl_mem[lbl_addr];

  function automatic int weight_of(input int r);
`ifdef KNN_VOTER_WEIGHTED_EN
    return K - r;
`else
    return 1;
`endif
  endfunction

  task automatic model(input int np, output int n, output int ecls, output int evotes);
    int cnt [NCLASS];
    n = (np < K) ? np : K;
    for (int c = 0; c < NCLASS; c++) cnt[c] = 0;
    for (int r = 0; r < n; r++) cnt[lab[r]] += weight_of(r);
    ecls   = 0;
    evotes = cnt[0];
    for (int c = 1; c < NCLASS; c++) if (cnt[c] > evotes) begin ecls = c; evotes = cnt[c]; end
  endtask

  task automatic setup_list();
    int base;
    base = $urandom_range(0, 255);
    for (int a = 0; a < 256; a++) lbl_mem[a] = LW'($urandom_range(0, NCLASS - 1));
    for (int r = 0; r < 16; r++) idx_list[r] = IW'(base + r * 7);
    for (int r = 0; r < K; r++) lbl_mem[idx_list[r]] = LW'(lab[r]);
  endtask

  task automatic random_labels();
    for (int r = 0; r < K; r++) lab[r] = $urandom_range(0, NCLASS - 1);
  endtask

  // One query: start, watch every cycle until tail cycles after the expected pulse.
  task automatic run_query(input int np, input string name, input int tail, input int busy_pulse);
    int n, ecls, evotes, exp_lat, first, nvalid, nre, badsel, busy1;
    logic [LW-1:0] got_cls;
    logic [CW-1:0] got_votes;
    model(np, n, ecls, evotes);
    setup_list();
    exp_lat = (n == 0) ? 2 : n + NCLASS + 3;
    first = -1; nvalid = 0; nre = 0; badsel = 0; busy1 = 0;
    got_cls = '0; got_votes = '0;
    @(negedge clk);
    start = 1'b1;
    npts  = IW'(np);
    for (int cyc = 1; cyc <= exp_lat + tail; cyc++) begin
      @(negedge clk);
      start = (busy_pulse != 0) && (cyc == busy_pulse);
      if (cyc == busy_pulse) npts = IW'($urandom_range(0, 20));
      if (cyc == 1) busy1 = int'(busy);
      if (lbl_re) begin
        nre++;
        if (int'(sel) >= n || lbl_addr !== idx_list[sel]) badsel++;
      end
      if (class_valid) begin
        nvalid++;
        if (first < 0) begin first = cyc; got_cls = class_out; got_votes = votes_out; end
      end
    end
    start = 1'b0;
    n_tests++; if (first !== exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, first, exp_lat); end
    n_tests++; if (nvalid !== 1) begin n_fail++; $display("FAIL %s valid_count: got %0d expected 1", name, nvalid); end
    n_tests++; if (got_cls !== LW'(ecls)) begin n_fail++; $display("FAIL %s class_out: got %0d expected %0d", name, got_cls, ecls); end
    n_tests++; if (got_votes !== CW'(evotes)) begin n_fail++; $display("FAIL %s votes_out: got %0d expected %0d", name, got_votes, evotes); end
    n_tests++; if (nre !== n) begin n_fail++; $display("FAIL %s read_count: got %0d expected %0d", name, nre, n); end
    n_tests++; if (badsel !== 0) begin n_fail++; $display("FAIL %s read_addr: got %0d bad reads expected 0", name, badsel); end
    n_tests++; if (busy1 !== 1) begin n_fail++; $display("FAIL %s busy_after_start: got %0d expected 1", name, busy1); end
    if (tail > 0) begin
      n_tests++; if (class_out !== LW'(ecls) || votes_out !== CW'(evotes)) begin
        n_fail++; $display("FAIL %s hold: got %0d/%0d expected %0d/%0d", name, class_out, votes_out, ecls, evotes);
      end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_idle: got %0d expected 0", name, busy); end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if (sel !== 4'd0 || lbl_addr !== '0 || lbl_re !== 1'b0 || busy !== 1'b0 ||
        class_valid !== 1'b0 || class_out !== '0 || votes_out !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got sel=%0d addr=%0d re=%0d busy=%0d cv=%0d cls=%0d votes=%0d expected all 0",
               name, sel, lbl_addr, lbl_re, busy, class_valid, class_out, votes_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; npts = '0;
    for (int r = 0; r < 16; r++) idx_list[r] = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_directed();
    lab = '{1, 1, 2, 3, 2, 2, 0, 1, 2, 3};
    run_query(20, "majority", 2, 0);
    lab = '{3, 3, 3, 0, 0, 0, 1, 1, 2, 2};
    run_query(20, "tie", 2, 0);
    lab = '{2, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    run_query(3, "short_list", 2, 0);
    run_query(0, "empty_list", 2, 0);
    run_query(10, "exact_k", 2, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      random_labels();
      run_query($urandom_range(0, 20), "random", 1, 0);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    for (int r = 0; r < K; r++) lab[r] = 3;
    run_query(10, "pre_abort", 1, 0);
    setup_list();
    @(negedge clk);
    start = 1'b1; npts = 8'd10;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++; if (sel !== 4'd4 || lbl_re !== 1'b1) begin n_fail++; $display("FAIL abort_rank: got sel=%0d re=%0d expected 4/1", sel, lbl_re); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("abort");
    nv = 0;
    repeat (20) begin @(negedge clk); if (class_valid) nv++; end
    n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nv); end
    lab = '{0, 1, 1, 2, 0, 1, 2, 2, 1, 0};
    run_query(10, "after_abort", 1, 0);
  endtask

  task automatic test_start_while_busy();
    random_labels();
    run_query(10, "busy_start_rd", 2, 5);
    random_labels();
    run_query(4, "busy_start_clr", 2, 1);
  endtask

  task automatic test_back_to_back();
    int nv;
    random_labels();
    run_query(7, "b2b_first", 0, 0);
    random_labels();
    run_query(9, "b2b_second", 0, 0);
    start = 1'b1; npts = 8'd5;
    @(negedge clk);
    start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_in_out: got busy=%0d expected 0", busy); end
    nv = 0;
    repeat (20) begin @(negedge clk); if (class_valid) nv++; end
    n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL start_in_out_valid: got %0d pulses expected 0", nv); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
